// File: rtl/wavelet_ctrl_pkg.sv
// Shared definitions for the wavelet mode controller: mode codes, FSM
// state encoding and the mode -> datapath selector mapping.
package wavelet_ctrl_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_DN1    = 2'd1;
    localparam logic [1:0] MODE_DN2    = 2'd2;
    localparam logic [1:0] MODE_RECON  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FILL  = 2'd2
    } state_e;

    // Selector vector ordered {lvl1 denoise, lvl2 denoise, lvl2 reconstruct}.
    function automatic logic [2:0] mode_to_sel(input logic [1:0] mode);
        logic [2:0] sel;
        case (mode)
            MODE_BYPASS: sel = 3'b000;
            MODE_DN1:    sel = 3'b100;
            MODE_DN2:    sel = 3'b110;
            MODE_RECON:  sel = 3'b111;
            default:     sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/wmc_cycle_counter.sv
// Loadable down-counter that stops at zero. Shared by the drain and the
// refill phases of the mode controller.
module wmc_cycle_counter #(
    parameter int               CNT_W   = 5,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load takes priority; otherwise count down and park at zero.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/wavelet_mode_ctrl.sv
// Run-time mode controller for the wavelet delay/alignment stage.
// A request is taken in RUN; the old selectors are held while the pipeline
// drains, the new selectors are applied and output validity stays gated
// until the new path has refilled.
module wavelet_mode_ctrl
    import wavelet_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 20,
    parameter int FILL_M0      = 1,
    parameter int FILL_M1      = 3,
    parameter int FILL_M2      = 5,
    parameter int FILL_M3      = 22,
    parameter int CNT_W        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode_req,
    input  logic       mode_req_valid,
    output logic       mode_req_ready,
    output logic       denoised_lvl1_selector,
    output logic       denoised_lvl2_selector,
    output logic       reconstruct_lvl_2_selector,
    output logic [1:0] mode_cur,
    output logic       out_valid,
    output logic       switch_done
);

    // Counter holds (cycles - 1) so that a full 2^CNT_W cycle span fits.
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILL0_LOAD = CNT_W'(FILL_M0 - 1);
    localparam logic [CNT_W-1:0] FILL1_LOAD = CNT_W'(FILL_M1 - 1);
    localparam logic [CNT_W-1:0] FILL2_LOAD = CNT_W'(FILL_M2 - 1);
    localparam logic [CNT_W-1:0] FILL3_LOAD = CNT_W'(FILL_M3 - 1);

    function automatic logic [CNT_W-1:0] fill_load(input logic [1:0] mode);
        logic [CNT_W-1:0] val;
        case (mode)
            MODE_BYPASS: val = FILL0_LOAD;
            MODE_DN1:    val = FILL1_LOAD;
            MODE_DN2:    val = FILL2_LOAD;
            MODE_RECON:  val = FILL3_LOAD;
            default:     val = FILL0_LOAD;
        endcase
        return val;
    endfunction

    state_e           state_q, state_nxt;
    logic [1:0]       mode_cur_q, mode_cur_nxt;
    logic [1:0]       mode_pend_q, mode_pend_nxt;
    logic [2:0]       sel_q;
    logic             ready_q;
    logic             out_valid_q;
    logic             switch_done_q, switch_done_nxt;
    // Distinguishes a requested switch from the refill that follows reset,
    // which must not raise switch_done.
    logic             switch_active_q, switch_active_nxt;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;

    wmc_cycle_counter #(
        .CNT_W   (CNT_W),
        .RST_VAL (FILL0_LOAD)
    ) u_cycle_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    // Next-state logic: accept in RUN, hold old config in DRAIN, apply new in FILL.
    // NOTE: every signal driven here gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_nxt         = state_q;
        mode_cur_nxt      = mode_cur_q;
        mode_pend_nxt     = mode_pend_q;
        switch_done_nxt   = 1'b0;
        switch_active_nxt = switch_active_q;
        cnt_load          = 1'b0;
        cnt_load_val      = '0;

        case (state_q)
            ST_RUN: begin
                if (mode_req_valid && (mode_req != mode_cur_q)) begin
                    state_nxt         = ST_DRAIN;
                    mode_pend_nxt     = mode_req;
                    switch_active_nxt = 1'b1;
                    cnt_load          = 1'b1;
                    cnt_load_val      = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (cnt_zero) begin
                    state_nxt    = ST_FILL;
                    mode_cur_nxt = mode_pend_q;
                    cnt_load     = 1'b1;
                    cnt_load_val = fill_load(mode_pend_q);
                end
            end
            ST_FILL: begin
                if (cnt_zero) begin
                    state_nxt         = ST_RUN;
                    switch_done_nxt   = switch_active_q;
                    switch_active_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_FILL;
            end
        endcase
    end

    // State and registered outputs; every output is decoded from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_FILL;
            mode_cur_q      <= MODE_BYPASS;
            mode_pend_q     <= MODE_BYPASS;
            sel_q           <= 3'b000;
            ready_q         <= 1'b0;
            out_valid_q     <= 1'b0;
            switch_done_q   <= 1'b0;
            switch_active_q <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            mode_cur_q      <= mode_cur_nxt;
            mode_pend_q     <= mode_pend_nxt;
            sel_q           <= mode_to_sel(mode_cur_nxt);
            ready_q         <= (state_nxt == ST_RUN);
            out_valid_q     <= (state_nxt == ST_RUN);
            switch_done_q   <= switch_done_nxt;
            switch_active_q <= switch_active_nxt;
        end
    end

    assign mode_req_ready             = ready_q;
    assign out_valid                  = out_valid_q;
    assign switch_done                = switch_done_q;
    assign mode_cur                   = mode_cur_q;
    assign denoised_lvl1_selector     = sel_q[2];
    assign denoised_lvl2_selector     = sel_q[1];
    assign reconstruct_lvl_2_selector = sel_q[0];

endmodule

// File: tb/tb_wavelet_mode_ctrl.sv
// Self-checking bench for wavelet_mode_ctrl. The reference model is a
// timeline: each accepted switch records the cycle at which the selectors
// change and the cycle at which the path is valid again.
module tb_wavelet_mode_ctrl;

    localparam int D = 20;
    localparam int FILL_LAT [4] = '{1, 3, 5, 22};

    logic       clk;
    logic       rst_n;
    logic [1:0] mode_req;
    logic       mode_req_valid;
    logic       mode_req_ready;
    logic       denoised_lvl1_selector;
    logic       denoised_lvl2_selector;
    logic       reconstruct_lvl_2_selector;
    logic [1:0] mode_cur;
    logic       out_valid;
    logic       switch_done;

    wavelet_mode_ctrl #(
        .DRAIN_CYCLES (20),
        .FILL_M0      (1),
        .FILL_M1      (3),
        .FILL_M2      (5),
        .FILL_M3      (22),
        .CNT_W        (5)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .mode_req                   (mode_req),
        .mode_req_valid             (mode_req_valid),
        .mode_req_ready             (mode_req_ready),
        .denoised_lvl1_selector     (denoised_lvl1_selector),
        .denoised_lvl2_selector     (denoised_lvl2_selector),
        .reconstruct_lvl_2_selector (reconstruct_lvl_2_selector),
        .mode_cur                   (mode_cur),
        .out_valid                  (out_valid),
        .switch_done                (switch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec;
    int         n_err;
    // Model timeline, in clock edges since reset release.
    int         cyc;
    int         ready_at;
    int         sel_at;
    logic [1:0] m_old;
    logic [1:0] m_new;
    bit         done_arm;
    bit         hs;
    int         done_seen;
    logic       prev_ov;
    logic [2:0] prev_sel;

    function automatic logic [2:0] exp_sel(input logic [1:0] m);
        return {m != 2'd0, m >= 2'd2, m == 2'd3};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic compare_all();
        logic [1:0] ecur;
        logic       ev;
        logic       ed;
        logic [2:0] dsel;
        ev   = (cyc >= ready_at);
        ecur = (cyc >= sel_at) ? m_new : m_old;
        ed   = done_arm && (cyc == ready_at);
        dsel = {denoised_lvl1_selector, denoised_lvl2_selector, reconstruct_lvl_2_selector};
        check("out_valid",   32'(out_valid),      32'(ev));
        check("ready",       32'(mode_req_ready), 32'(ev));
        check("switch_done", 32'(switch_done),    32'(ed));
        check("mode_cur",    32'(mode_cur),       32'(ecur));
        check("selectors",   32'(dsel),           32'(exp_sel(ecur)));
        if (prev_ov === 1'b1 && out_valid === 1'b1)
            check("sel_stable_while_valid", 32'(dsel), 32'(prev_sel));
        prev_ov  = out_valid;
        prev_sel = dsel;
        if (switch_done === 1'b1) done_seen++;
    endtask

    // One clock: model the edge, then sample on the falling edge.
    task automatic tick();
        hs = mode_req_valid && (cyc >= ready_at);
        @(posedge clk);
        cyc++;
        if (hs && mode_req != m_new) begin
            m_old    = m_new;
            m_new    = mode_req;
            sel_at   = cyc + D;
            ready_at = cyc + D + FILL_LAT[mode_req];
            done_arm = 1'b1;
        end
        @(negedge clk);
        compare_all();
        if (hs) mode_req_valid = 1'b0;
    endtask

    task automatic wait_hs(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!hs && n < 200);
        check({tag, "_handshake"}, 32'(hs), 32'd1);
    endtask

    task automatic apply_reset();
        mode_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid",   32'(out_valid),      32'd0);
        check("rst_ready",       32'(mode_req_ready), 32'd0);
        check("rst_switch_done", 32'(switch_done),    32'd0);
        check("rst_mode_cur",    32'(mode_cur),       32'd0);
        check("rst_selectors",
              32'({denoised_lvl1_selector, denoised_lvl2_selector, reconstruct_lvl_2_selector}),
              32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        cyc      = 0;
        ready_at = FILL_LAT[0];
        sel_at   = 0;
        m_old    = 2'd0;
        m_new    = 2'd0;
        done_arm = 1'b0;
        prev_ov  = 1'b0;
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int low;
        int d0;
        n_vec          = 0;
        n_err          = 0;
        done_seen      = 0;
        hs             = 1'b0;
        mode_req       = 2'd0;
        mode_req_valid = 1'b0;
        rst_n          = 1'b1;
        cyc            = 0;
        ready_at       = FILL_LAT[0];
        sel_at         = 0;
        m_old          = 2'd0;
        m_new          = 2'd0;
        done_arm       = 1'b0;
        prev_ov        = 1'b0;
        prev_sel       = 3'b000;

        // Reset release, idle.
        #2;
        apply_reset();
        repeat (5) tick();
        check("no_done_after_reset", 32'(done_seen), 32'd0);

        // M0 -> M1: 23 cycles without valid output.
        mode_req = 2'd1; mode_req_valid = 1'b1;
        wait_hs("m1", n);
        check("m1_accept_latency", 32'(n), 32'd1);
        low = 0;
        while (out_valid === 1'b0 && low < 200) begin
            low++;
            tick();
        end
        check("m1_low_cycles", 32'(low), 32'd23);
        check("m1_done_count", 32'(done_seen), 32'd1);

        // M1 -> M3 while M0 is held valid behind it.
        mode_req = 2'd3; mode_req_valid = 1'b1;
        wait_hs("m3", n);
        mode_req = 2'd0; mode_req_valid = 1'b1;
        wait_hs("m0_held", n);
        check("m0_accept_delay", 32'(n), 32'd43);
        repeat (25) tick();
        check("m0_final_sel",
              32'({denoised_lvl1_selector, denoised_lvl2_selector, reconstruct_lvl_2_selector}),
              32'd0);

        // M0 -> M2, then a no-op M2 request.
        mode_req = 2'd2; mode_req_valid = 1'b1;
        wait_hs("m2", n);
        repeat (30) tick();
        d0 = done_seen;
        mode_req = 2'd2; mode_req_valid = 1'b1;
        wait_hs("m2_noop", n);
        check("noop_accept_latency", 32'(n), 32'd1);
        low = 0;
        repeat (10) begin
            tick();
            if (out_valid !== 1'b1) low++;
        end
        check("noop_valid_held", 32'(low), 32'd0);
        check("noop_no_done", 32'(done_seen), 32'(d0));

        // Back to M0, then reset 10 cycles into an M0 -> M3 drain.
        mode_req = 2'd0; mode_req_valid = 1'b1;
        wait_hs("m0", n);
        repeat (25) tick();
        mode_req = 2'd3; mode_req_valid = 1'b1;
        wait_hs("m3_abort", n);
        repeat (10) tick();
        apply_reset();
        tick();
        check("valid_after_reset", 32'(out_valid), 32'd1);

        // Random request stream; requests stay stable until accepted.
        repeat (1500) begin
            if (!mode_req_valid) begin
                mode_req = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) mode_req_valid = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wavelet_mode_ctrl.md
# wavelet_mode_ctrl

Run-time mode controller for the wavelet delay/alignment stage. Accepts a processing-mode request over a valid/ready handshake and drives the three datapath selectors: lvl-1 denoise, lvl-2 denoise and lvl-2 reconstruct. It changes them only after the in-flight samples have drained, then gates output validity until the new path has refilled. It sits between the PS-side register interface and the delay/mux alignment stage.

## Interface
- `DRAIN_CYCLES`, 20: cycles the old configuration is held after a request is accepted.
- `FILL_M0`, 1: refill latency for mode 0 (bypass).
- `FILL_M1`, 3: refill latency for mode 1 (lvl-1 denoise).
- `FILL_M2`, 5: refill latency for mode 2 (lvl-1 + lvl-2 denoise).
- `FILL_M3`, 22: refill latency for mode 3 (denoise + lvl-2 reconstruct).
- `CNT_W`, 5: counter width. Every DRAIN/FILL value must be ≥1 and ≤ 2^CNT_W.
- `clk` in 1: single clock. All logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset. Assertion takes effect immediately; release is synchronous to `clk`.
- `mode_req` in 2: requested mode, 0..3.
- `mode_req_valid` in 1: request valid.
- `mode_req_ready` out 1: controller can accept a request.
- `denoised_lvl1_selector` out 1: registered.
- `denoised_lvl2_selector` out 1: registered.
- `reconstruct_lvl_2_selector` out 1: registered.
- `mode_cur` out 2: mode currently applied to the selectors.
- `out_valid` out 1: output samples of the aligned datapath are valid.
- `switch_done` out 1: one-cycle pulse when a switch completes.

## Operation
- Selector mapping, written as {lvl1, lvl2, recon}:
  - M0 = 000
  - M1 = 100
  - M2 = 110
  - M3 = 111
- FSM states:
  - RUN: `mode_req_ready`=1, `out_valid`=1.
  - DRAIN: ready=0, out_valid=0, old selectors held.
  - FILL: ready=0, out_valid=0, new selectors applied.
- Transitions:
  - RUN → DRAIN on handshake (`mode_req_valid & mode_req_ready`) when `mode_req != mode_cur`. The counter loads DRAIN_CYCLES-1 and the requested mode is captured in `mode_pend`.
  - RUN, handshake with `mode_req == mode_cur`: accepted as a no-op. State stays RUN, out_valid stays 1, no `switch_done`.
  - DRAIN: counter decrements each cycle. At count 0 it goes to FILL. On that same edge `mode_cur` and the selectors take `mode_pend`, and the counter loads FILL_Mx-1 for the new mode.
  - FILL: counter decrements. At count 0 it goes to RUN and `switch_done` pulses for 1 cycle.
- Requests arriving while ready=0 are not accepted. The requester holds `mode_req_valid` and `mode_req` stable until the handshake; the controller never drops a request.
- A change of `mode_req` in DRAIN/FILL has no effect on the switch in progress.
- Reset values:
  - state FILL, counter FILL_M0-1, `mode_cur`=0, selectors 000.
  - `out_valid`=0, `mode_req_ready`=0, `switch_done`=0, `mode_pend`=0.
- Reset release: `out_valid` rises FILL_M0 cycles after the first clock edge, with no `switch_done` pulse on that first fill.
- Reset asserted mid-DRAIN/FILL: the switch is abandoned and the controller returns to the reset values above.

## Timing
- Request accepted at edge E0.
  - From E0: `out_valid`=0, `mode_req_ready`=0.
  - E0+DRAIN_CYCLES: selectors and `mode_cur` update.
  - E0+DRAIN_CYCLES+FILL_Mnew: `out_valid`=1, ready=1 and `switch_done`=1 for one cycle.
- Example, M0→M3 with defaults: out_valid is low for 42 cycles.
- All outputs are registered. There is no combinational path from input to output, including ready.
- Back-to-back requests are possible: a new handshake may occur on the first RUN cycle after a switch.
- Selectors change only on the DRAIN→FILL edge and never while `out_valid`=1.

## Structure
- Package `wavelet_ctrl_pkg` holds:
  - mode constants MODE_BYPASS=0, MODE_DN1=1, MODE_DN2=2, MODE_RECON=3;
  - FSM state encoding (RUN, DRAIN, FILL);
  - a function mapping a mode to the 3-bit selector vector.
- Sub-module `wmc_cycle_counter`: a loadable down-counter with a `zero` flag, CNT_W bits, async active-low reset. It is instantiated once and loaded with either the DRAIN or the FILL value.

## Test plan
- Reset release, no requests → `out_valid` rises after 1 cycle; selectors 000; `mode_req_ready`=1; `switch_done` never pulses.
- Request M1 from RUN → `out_valid` is low for 23 cycles. Selectors become 100 exactly 20 cycles after the handshake. `switch_done` pulses once on cycle 23.
- Request M3, then hold M0 valid throughout the switch → M0 is not accepted until the M3 switch completes (42 cycles). It is then accepted on the next cycle, and selectors reach 000 a further 20 cycles later.
- Request equal to `mode_cur` (M2→M2) → handshake completes, `out_valid` never drops, no `switch_done`, selectors unchanged.
- `rst_n` asserted 10 cycles into the DRAIN of an M0→M3 switch → all outputs go to reset values at once (selectors 000, `mode_cur`=0). After release, `out_valid` returns after 1 cycle.
- Random request stream with stable-hold compliance → scoreboard checks that the selectors always match the mapping for `mode_cur` and never change while `out_valid`=1.
